hazard_fwd_ctrl: RTL and testbench

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

---
 rtl/hazard_fwd_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// ============================================================================
//  Module   : hazard_fwd_ctrl
//  Brief    : Decode-stage hazard detection, forwarding-select generation and
//             pipeline stall control backed by an EX/MEM destination scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_fwd_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        DecValid,
    input  logic [4:0]  DecAa,
    input  logic [4:0]  DecAb,
    input  logic        DecUsesA,
    input  logic        DecUsesB,
    input  logic [4:0]  DecAw,
    input  logic        DecRegWrite,
    input  logic        DecMemRead,
    input  logic        DecFlagWrite,
    input  logic        DecFlagBr,
    input  logic        HoldReq,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic        PCWrite,
    output logic        IfIdWrite,
    output logic        DecBubble,
    output logic [15:0] StallCount
);

    localparam logic [1:0]  C_FWD_RF  = 2'b00;
    localparam logic [1:0]  C_FWD_EX  = 2'b01;
    localparam logic [1:0]  C_FWD_WB  = 2'b10;
    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic       valid;
        logic [4:0] aw;
        logic       regwrite;
        logic       memread;
        logic       flagwrite;
    } slot_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    slot_t       r_s1;
    slot_t       r_s2;
    slot_t       w_dec_slot;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_stall_count;

    logic w_s1_prod_a, w_s1_prod_b, w_s2_prod_a, w_s2_prod_b;
    logic w_load_use, w_flag_haz, w_stall;
    logic w_unused_s2;

    // X31 is the zero register: it never produces a value worth forwarding.
    function automatic logic produces(input slot_t s, input logic [4:0] r);
        return s.valid && s.regwrite && (s.aw == r) && (r != 5'd31);
    endfunction

    assign w_dec_slot  = '{valid: DecValid, aw: DecAw, regwrite: DecRegWrite,
                           memread: DecMemRead, flagwrite: DecFlagWrite};

    assign w_s1_prod_a = DecUsesA && produces(r_s1, DecAa);
    assign w_s1_prod_b = DecUsesB && produces(r_s1, DecAb);
    assign w_s2_prod_a = DecUsesA && produces(r_s2, DecAa);
    assign w_s2_prod_b = DecUsesB && produces(r_s2, DecAb);

    assign w_load_use  = DecValid && r_s1.memread && (w_s1_prod_a || w_s1_prod_b);
    assign w_flag_haz  = DecValid && DecFlagBr && r_s1.valid && r_s1.flagwrite;
    // A stall always empties S1, so a second back-to-back stall cannot arise from the same producer.
    assign w_stall     = (w_load_use || w_flag_haz) && !HoldReq && (r_state == RUN);

    // MEM-stage load/flag status never changes a decision; kept for slot symmetry.
    assign w_unused_s2 = r_s2.memread ^ r_s2.flagwrite;

    always_comb begin
        ForwardA  = C_FWD_RF;
        ForwardB  = C_FWD_RF;
        PCWrite   = 1'b1;
        IfIdWrite = 1'b1;
        DecBubble = 1'b0;

        if (w_s1_prod_a && !r_s1.memread) ForwardA = C_FWD_EX;
        else if (w_s2_prod_a)             ForwardA = C_FWD_WB;

        if (w_s1_prod_b && !r_s1.memread) ForwardB = C_FWD_EX;
        else if (w_s2_prod_b)             ForwardB = C_FWD_WB;

        if (w_stall) begin
            PCWrite   = 1'b0;
            IfIdWrite = 1'b0;
            DecBubble = 1'b1;
        end else if (HoldReq) begin
            PCWrite   = 1'b0;
            IfIdWrite = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_stall)  w_state_nxt = STALL;
            STALL:   if (!HoldReq) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RUN;
            r_s1          <= '0;
            r_s2          <= '0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (HoldReq) begin
                r_s1 <= r_s1;
                r_s2 <= r_s2;
            end else if (w_stall) begin
                r_s1 <= '0;
                r_s2 <= r_s1;
                if (r_stall_count != C_CNT_MAX) r_stall_count <= r_stall_count + 16'd1;
            end else begin
                r_s1 <= w_dec_slot;
                r_s2 <= r_s1;
            end
        end
    end

    assign StallCount = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
// ============================================================================
//  Module   : tb_hazard_fwd_ctrl
//  Brief    : Directed, table-driven self-checking bench for hazard_fwd_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_fwd_ctrl;

    logic        clk;
    logic        reset;
    logic        DecValid;
    logic [4:0]  DecAa, DecAb, DecAw;
    logic        DecUsesA, DecUsesB;
    logic        DecRegWrite, DecMemRead, DecFlagWrite, DecFlagBr, HoldReq;
    logic [1:0]  ForwardA, ForwardB;
    logic        PCWrite, IfIdWrite, DecBubble;
    logic [15:0] StallCount;

    int checks   = 0;
    int failures = 0;

    hazard_fwd_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .DecValid     (DecValid),
        .DecAa        (DecAa),
        .DecAb        (DecAb),
        .DecUsesA     (DecUsesA),
        .DecUsesB     (DecUsesB),
        .DecAw        (DecAw),
        .DecRegWrite  (DecRegWrite),
        .DecMemRead   (DecMemRead),
        .DecFlagWrite (DecFlagWrite),
        .DecFlagBr    (DecFlagBr),
        .HoldReq      (HoldReq),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB),
        .PCWrite      (PCWrite),
        .IfIdWrite    (IfIdWrite),
        .DecBubble    (DecBubble),
        .StallCount   (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       valid;
        logic [4:0] aa;
        logic [4:0] ab;
        logic       ua;
        logic       ub;
        logic [4:0] aw;
        logic       rw;
        logic       mr;
        logic       fw;
        logic       fbr;
        logic       hold;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       pcw;
        logic       ifw;
        logic       bub;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        DecValid     = v.valid;
        DecAa        = v.aa;
        DecAb        = v.ab;
        DecUsesA     = v.ua;
        DecUsesB     = v.ub;
        DecAw        = v.aw;
        DecRegWrite  = v.rw;
        DecMemRead   = v.mr;
        DecFlagWrite = v.fw;
        DecFlagBr    = v.fbr;
        HoldReq      = v.hold;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl(input string name, input logic pcw, input logic ifw, input logic bub);
        check(name, 32'({PCWrite, IfIdWrite, DecBubble}), 32'({pcw, ifw, bub}));
    endtask

    vec_t ld2, rd2, rd14;

    initial begin
        //            valid aa     ab     ua  ub  aw     rw  mr  fw  fbr hold  fa     fb     pcw ifw bub cnt
        vt[0]  = '{'1, 5'd3,  5'd4,  '1, '1, 5'd1,  '1, '0, '0, '0, '0, 2'b00, 2'b00, '1, '1, '0, 16'd0};
        vt[1]  = '{'1, 5'd1,  5'd6,  '1, '1, 5'd5,  '1, '0, '0, '0, '0, 2'b01, 2'b00, '1, '1, '0, 16'd0};
        vt[2]  = '{'1, 5'd1,  5'd9,  '1, '1, 5'd7,  '1, '0, '0, '0, '0, 2'b10, 2'b00, '1, '1, '0, 16'd0};
        vt[3]  = '{'1, 5'd1,  5'd5,  '0, '1, 5'd10, '1, '0, '0, '0, '0, 2'b00, 2'b10, '1, '1, '0, 16'd0};
        vt[4]  = '{'1, 5'd7,  5'd10, '1, '1, 5'd10, '1, '0, '0, '0, '0, 2'b10, 2'b01, '1, '1, '0, 16'd0};
        vt[5]  = '{'1, 5'd10, 5'd10, '1, '1, 5'd11, '0, '0, '0, '0, '0, 2'b01, 2'b01, '1, '1, '0, 16'd0};
        vt[6]  = '{'1, 5'd2,  5'd3,  '1, '1, 5'd31, '1, '0, '0, '0, '0, 2'b00, 2'b00, '1, '1, '0, 16'd0};
        vt[7]  = '{'1, 5'd31, 5'd31, '1, '1, 5'd12, '1, '0, '0, '0, '0, 2'b00, 2'b00, '1, '1, '0, 16'd0};
        vt[8]  = '{'1, 5'd31, 5'd12, '1, '1, 5'd13, '0, '0, '0, '0, '0, 2'b00, 2'b01, '1, '1, '0, 16'd0};
        vt[9]  = '{'1, 5'd20, 5'd0,  '1, '0, 5'd2,  '1, '1, '0, '0, '0, 2'b00, 2'b00, '1, '1, '0, 16'd0};
        vt[10] = '{'1, 5'd15, 5'd2,  '1, '1, 5'd14, '1, '0, '0, '0, '0, 2'b00, 2'b00, '0, '0, '1, 16'd0};
        vt[11] = '{'1, 5'd15, 5'd2,  '1, '1, 5'd14, '1, '0, '0, '0, '0, 2'b00, 2'b10, '1, '1, '0, 16'd1};
        vt[12] = '{'1, 5'd14, 5'd0,  '1, '0, 5'd16, '1, '0, '0, '0, '0, 2'b01, 2'b00, '1, '1, '0, 16'd1};
        vt[13] = '{'1, 5'd0,  5'd0,  '0, '0, 5'd17, '1, '1, '1, '0, '0, 2'b00, 2'b00, '1, '1, '0, 16'd1};
        vt[14] = '{'1, 5'd17, 5'd0,  '1, '0, 5'd0,  '0, '0, '0, '1, '0, 2'b00, 2'b00, '0, '0, '1, 16'd1};
        vt[15] = '{'1, 5'd17, 5'd0,  '1, '0, 5'd0,  '0, '0, '0, '1, '0, 2'b10, 2'b00, '1, '1, '0, 16'd2};
        vt[16] = '{'1, 5'd3,  5'd0,  '1, '0, 5'd31, '1, '0, '1, '0, '0, 2'b00, 2'b00, '1, '1, '0, 16'd2};
        vt[17] = '{'1, 5'd0,  5'd0,  '0, '0, 5'd0,  '0, '0, '0, '1, '0, 2'b00, 2'b00, '0, '0, '1, 16'd2};
        vt[18] = '{'1, 5'd0,  5'd0,  '0, '0, 5'd0,  '0, '0, '0, '1, '0, 2'b00, 2'b00, '1, '1, '0, 16'd3};
        vt[19] = '{'1, 5'd0,  5'd0,  '0, '0, 5'd0,  '0, '0, '1, '0, '0, 2'b00, 2'b00, '1, '1, '0, 16'd3};
        vt[20] = '{'0, 5'd0,  5'd0,  '0, '0, 5'd0,  '0, '0, '0, '1, '0, 2'b00, 2'b00, '1, '1, '0, 16'd3};
        vt[21] = '{'1, 5'd0,  5'd0,  '0, '0, 5'd4,  '1, '1, '0, '0, '0, 2'b00, 2'b00, '1, '1, '0, 16'd3};
        vt[22] = '{'0, 5'd4,  5'd0,  '1, '0, 5'd0,  '0, '0, '0, '0, '0, 2'b00, 2'b00, '1, '1, '0, 16'd3};
        vt[23] = '{'1, 5'd4,  5'd0,  '1, '0, 5'd0,  '0, '0, '0, '0, '0, 2'b10, 2'b00, '1, '1, '0, 16'd3};

        ld2  = '{'1, 5'd20, 5'd0,  '1, '0, 5'd2,  '1, '1, '0, '0, '0, 2'b00, 2'b00, '1, '1, '0, 16'd0};
        rd2  = '{'1, 5'd15, 5'd2,  '1, '1, 5'd14, '1, '0, '0, '0, '0, 2'b00, 2'b00, '1, '1, '0, 16'd0};
        rd14 = '{'1, 5'd14, 5'd0,  '1, '0, 5'd16, '1, '0, '0, '0, '0, 2'b00, 2'b00, '1, '1, '0, 16'd0};

        // Reset state
        reset = 1'b1;
        drive('{'0, 5'd0, 5'd0, '0, '0, 5'd0, '0, '0, '0, '0, '0, 2'b00, 2'b00, '0, '0, '0, 16'd0});
        #12;
        reset = 1'b0;
        check("rst_fwdA", 32'(ForwardA), 32'(2'b00));
        check("rst_fwdB", 32'(ForwardB), 32'(2'b00));
        chk_ctrl("rst_ctrl", 1'b1, 1'b1, 1'b0);
        check("rst_cnt", 32'(StallCount), 32'(16'd0));
        step();

        // Table-driven cycle sequence
        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            #2;
            check($sformatf("v%0d_fwd", i), 32'({ForwardA, ForwardB}), 32'({vt[i].fa, vt[i].fb}));
            chk_ctrl($sformatf("v%0d_ctrl", i), vt[i].pcw, vt[i].ifw, vt[i].bub);
            check($sformatf("v%0d_cnt", i), 32'(StallCount), 32'(vt[i].cnt));
            step();
        end

        // HoldReq during a load-use: everything frozen, stall taken after release
        drive(ld2);
        step();
        rd2.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(rd2);
            #2;
            chk_ctrl($sformatf("hold%0d_ctrl", k), 1'b0, 1'b0, 1'b0);
            check($sformatf("hold%0d_fwdB", k), 32'(ForwardB), 32'(2'b00));
            check($sformatf("hold%0d_cnt", k), 32'(StallCount), 32'(16'd3));
            step();
        end
        rd2.hold = 1'b0;
        drive(rd2);
        #2;
        chk_ctrl("hold_rel_ctrl", 1'b0, 1'b0, 1'b1);
        check("hold_rel_cnt", 32'(StallCount), 32'(16'd3));
        step();
        #2;
        check("hold_post_fwdB", 32'(ForwardB), 32'(2'b10));
        chk_ctrl("hold_post_ctrl", 1'b1, 1'b1, 1'b0);
        check("hold_post_cnt", 32'(StallCount), 32'(16'd4));
        step();

        // Asynchronous reset in the middle of a stall cycle
        drive(ld2);
        step();
        drive(rd2);
        #2;
        chk_ctrl("rs_stall_ctrl", 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        check("rs_fwd", 32'({ForwardA, ForwardB}), 32'(4'b0000));
        chk_ctrl("rs_ctrl", 1'b1, 1'b1, 1'b0);
        check("rs_cnt", 32'(StallCount), 32'(16'd0));
        #1;
        reset = 1'b0;
        step();
        drive(rd14);
        #2;
        check("rs_after_fwdA", 32'(ForwardA), 32'(2'b01));
        chk_ctrl("rs_after_ctrl", 1'b1, 1'b1, 1'b0);
        check("rs_after_cnt", 32'(StallCount), 32'(16'd0));
        step();

        // Counter saturation, preloaded just below the ceiling
        force dut.r_stall_count = 16'hFFFE;
        #1;
        release dut.r_stall_count;
        drive(ld2);
        step();
        drive(rd2);
        #2;
        chk_ctrl("sat1_ctrl", 1'b0, 1'b0, 1'b1);
        check("sat1_cnt", 32'(StallCount), 32'(16'hFFFE));
        step();
        #2;
        check("sat2_cnt", 32'(StallCount), 32'(16'hFFFF));
        drive(ld2);
        step();
        drive(rd2);
        #2;
        chk_ctrl("sat3_ctrl", 1'b0, 1'b0, 1'b1);
        step();
        #2;
        check("sat4_cnt", 32'(StallCount), 32'(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
